// File: rtl/iserdes_lane_aligner_pkg.sv
// Shared definitions for the ISERDES lane aligner: per-lane FSM state encoding
// and a word bit-reversal helper.
package iserdes_lane_aligner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } lane_state_e;

  localparam int MAX_W = 8;

  // Reverses a full MAX_W word. A DATA_WIDTH word zero-extended to MAX_W comes
  // back reversed in the top DATA_WIDTH bits of the result.
  function automatic logic [MAX_W-1:0] bitreverse(input logic [MAX_W-1:0] w);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = w[MAX_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/iserdes_lane_align_fsm.sv
// Single-lane word aligner: compares the (optionally reversed) lane word with the
// training pattern, issues bitslip pulses until it matches, and registers dout.
module iserdes_lane_align_fsm
  import iserdes_lane_aligner_pkg::*;
#(
  parameter int          DATA_WIDTH    = 8,
  parameter logic [15:0] TRAIN_PATTERN = 16'h00E5,
  parameter int          MATCH_COUNT   = 16,
  parameter int          SLIP_WAIT     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rev_flag,
  input  logic                  align_start,
  output logic                  bitslip,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  locked,
  output logic                  align_err,
  output logic [3:0]            slip_count
);

  localparam logic [DATA_WIDTH-1:0] PATTERN    = TRAIN_PATTERN[DATA_WIDTH-1:0];
  localparam logic [7:0]            MATCH_LAST = 8'(MATCH_COUNT);
  localparam logic [3:0]            WAIT_LAST  = 4'(SLIP_WAIT - 1);
  localparam logic [3:0]            SLIP_MAX   = 4'(DATA_WIDTH);

  lane_state_e           state_q, state_d;
  logic [7:0]            match_q, match_d, match_inc;
  logic [3:0]            slip_q, slip_d;
  logic [3:0]            wait_q, wait_d;
  logic                  bitslip_q, bitslip_d;
  logic                  locked_q, locked_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [MAX_W-1:0]      rev_full;
  logic [DATA_WIDTH-1:0] word;

  always_comb begin
    rev_full  = bitreverse(MAX_W'(din));
    word      = rev_flag ? rev_full[MAX_W-1 -: DATA_WIDTH] : din;
    match_inc = match_q + 8'd1;

    state_d   = state_q;
    match_d   = match_q;
    slip_d    = slip_q;
    wait_d    = wait_q;
    locked_d  = locked_q;
    err_d     = err_q;
    bitslip_d = 1'b0;
    dout_d    = word;

    if (align_start) begin
      state_d  = ST_CHECK;
      match_d  = '0;
      slip_d   = '0;
      wait_d   = '0;
      locked_d = 1'b0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_CHECK: begin
          if (word == PATTERN) begin
            match_d = match_inc;
            if (match_inc == MATCH_LAST) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_d = '0;
            if (slip_q == SLIP_MAX) begin
              state_d = ST_FAIL;
              err_d   = 1'b1;
            end else begin
              // Pulse is registered so it is high for the whole SLIP cycle.
              state_d   = ST_SLIP;
              bitslip_d = 1'b1;
            end
          end
        end
        ST_SLIP: begin
          slip_d  = (slip_q == SLIP_MAX) ? slip_q : slip_q + 4'd1;
          wait_d  = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == WAIT_LAST) state_d = ST_CHECK;
          else                     wait_d  = wait_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      match_q   <= '0;
      slip_q    <= '0;
      wait_q    <= '0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      wait_q    <= wait_d;
      bitslip_q <= bitslip_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      dout_q    <= dout_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign dout       = dout_q;
  assign locked     = locked_q;
  assign align_err  = err_q;
  assign slip_count = slip_q;

endmodule

// File: rtl/iserdes_lane_aligner.sv
// Multi-lane ISERDES word aligner: one independent aligner per lane, plus an
// all-lanes-locked flag.
module iserdes_lane_aligner
  import iserdes_lane_aligner_pkg::*;
#(
  parameter int          NLANES        = 2,
  parameter int          DATA_WIDTH    = 8,
  parameter logic [15:0] TRAIN_PATTERN = 16'h00E5,
  parameter int          MATCH_COUNT   = 16,
  parameter int          SLIP_WAIT     = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NLANES*DATA_WIDTH-1:0] din,
  input  logic [NLANES-1:0]            rev_flag,
  input  logic                         align_start,
  output logic [NLANES-1:0]            bitslip,
  output logic [NLANES*DATA_WIDTH-1:0] dout,
  output logic [NLANES-1:0]            locked,
  output logic [NLANES-1:0]            align_err,
  output logic [NLANES*4-1:0]          slip_count,
  output logic                         align_done
);

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    iserdes_lane_align_fsm #(
      .DATA_WIDTH    (DATA_WIDTH),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .MATCH_COUNT   (MATCH_COUNT),
      .SLIP_WAIT     (SLIP_WAIT)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .din         (din[i*DATA_WIDTH +: DATA_WIDTH]),
      .rev_flag    (rev_flag[i]),
      .align_start (align_start),
      .bitslip     (bitslip[i]),
      .dout        (dout[i*DATA_WIDTH +: DATA_WIDTH]),
      .locked      (locked[i]),
      .align_err   (align_err[i]),
      .slip_count  (slip_count[i*4 +: 4])
    );
  end

  assign align_done = &locked;

endmodule

// File: tb/tb_iserdes_lane_aligner.sv
// Bench for iserdes_lane_aligner with a two-lane ISERDES model whose bitslip
// rotates the lane word left by one, two cycles after the pulse.
module tb_iserdes_lane_aligner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic [1:0]  rev_flag;
  logic        align_start;
  logic [1:0]  bitslip;
  logic [15:0] dout;
  logic [1:0]  locked;
  logic [1:0]  align_err;
  logic [7:0]  slip_count;
  logic        align_done;

  iserdes_lane_aligner dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .rev_flag    (rev_flag),
    .align_start (align_start),
    .bitslip     (bitslip),
    .dout        (dout),
    .locked      (locked),
    .align_err   (align_err),
    .slip_count  (slip_count),
    .align_done  (align_done)
  );

  always #5 clk = ~clk;

  // ISERDES model
  logic [7:0] base [2];
  int         off [2];
  int         ref_s [2];
  int         slips_m [2] = '{0, 0};
  logic [1:0] pipe0 = 2'b00;
  logic [1:0] pipe1 = 2'b00;

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int k = 0; k < (n % 8); k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (pipe1[i]) slips_m[i] = slips_m[i] + 1;
    pipe1 = pipe0;
    pipe0 = bitslip;
  end

  assign din = {rotl(base[1], off[1] + slips_m[1] - ref_s[1]),
                rotl(base[0], off[0] + slips_m[0] - ref_s[0])};

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  int pulses0, pulses1, lock_cyc0, lock_cyc1;
  int pulse_t1[$];

  task automatic setup(input logic [7:0] b0, input int o0, input logic r0,
                       input logic [7:0] b1, input int o1, input logic r1);
    @(negedge clk);
    ref_s[0] = slips_m[0];
    ref_s[1] = slips_m[1];
    base[0] = b0; off[0] = o0;
    base[1] = b1; off[1] = o1;
    rev_flag = {r1, r0};
  endtask

  task automatic start_align();
    @(negedge clk);
    align_start = 1'b1;
    @(negedge clk);
    align_start = 1'b0;
  endtask

  task automatic run_until_done(input int bound);
    int cyc;
    cyc = 0;
    pulses0 = 0; pulses1 = 0; lock_cyc0 = -1; lock_cyc1 = -1;
    pulse_t1.delete();
    while (cyc < bound && !((locked[0] | align_err[0]) && (locked[1] | align_err[1]))) begin
      @(negedge clk);
      cyc++;
      if (bitslip[0]) pulses0++;
      if (bitslip[1]) begin pulses1++; pulse_t1.push_back(cyc); end
      if (locked[0] && lock_cyc0 < 0) lock_cyc0 = cyc;
      if (locked[1] && lock_cyc1 < 0) lock_cyc1 = cyc;
    end
    check("done_within_bound", int'(cyc < bound), 1);
    repeat (4) begin
      @(negedge clk);
      if (bitslip[0]) pulses0++;
      if (bitslip[1]) pulses1++;
    end
  endtask

  typedef struct {
    logic [7:0] b0; int o0; logic r0;
    logic [7:0] b1; int o1; logic r1;
    logic [1:0] lk; logic [1:0] er;
    int s0; int s1;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, cyc;
    vecs[0] = '{8'hE5, 0, 1'b0, 8'hE5, 5, 1'b0, 2'b11, 2'b00, 0, 3};
    vecs[1] = '{8'hE5, 0, 1'b0, 8'hA7, 0, 1'b1, 2'b11, 2'b00, 0, 0};
    vecs[2] = '{8'hE5, 2, 1'b0, 8'hA7, 0, 1'b0, 2'b01, 2'b10, 6, 8};
    vecs[3] = '{8'h00, 0, 1'b0, 8'hE5, 1, 1'b0, 2'b10, 2'b01, 8, 7};
    vecs[4] = '{8'hA7, 4, 1'b1, 8'hFF, 0, 1'b0, 2'b01, 2'b10, 4, 8};

    reset = 1'b1; align_start = 1'b0; rev_flag = 2'b00;
    base[0] = 8'hE5; base[1] = 8'hE5; off[0] = 0; off[1] = 0;
    ref_s[0] = 0; ref_s[1] = 0;
    repeat (2) @(negedge clk);
    check("reset_bitslip", int'(bitslip), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_align_err", int'(align_err), 0);
    check("reset_dout", int'(dout), 0);
    check("reset_slip_count", int'(slip_count), 0);
    check("reset_align_done", int'(align_done), 0);
    reset = 1'b0;
    cnt = 0;
    repeat (6) begin @(negedge clk); if (bitslip != 2'b00) cnt++; end
    check("idle_no_slip", cnt, 0);
    check("idle_not_locked", int'(locked), 0);

    for (int v = 0; v < 5; v++) begin
      setup(vecs[v].b0, vecs[v].o0, vecs[v].r0, vecs[v].b1, vecs[v].o1, vecs[v].r1);
      start_align();
      run_until_done(400);
      check($sformatf("v%0d_locked", v), int'(locked), int'(vecs[v].lk));
      check($sformatf("v%0d_align_err", v), int'(align_err), int'(vecs[v].er));
      check($sformatf("v%0d_slip_count0", v), int'(slip_count[3:0]), vecs[v].s0);
      check($sformatf("v%0d_slip_count1", v), int'(slip_count[7:4]), vecs[v].s1);
      check($sformatf("v%0d_pulses0", v), pulses0, vecs[v].s0);
      check($sformatf("v%0d_pulses1", v), pulses1, vecs[v].s1);
      check($sformatf("v%0d_align_done", v), int'(align_done), int'(&vecs[v].lk));
      if (vecs[v].lk[0]) check($sformatf("v%0d_dout0", v), int'(dout[7:0]), 8'hE5);
      if (vecs[v].lk[1]) check($sformatf("v%0d_dout1", v), int'(dout[15:8]), 8'hE5);
      if (v == 0) begin
        check("lane0_lock_cycle", lock_cyc0, 16);
        check("lane1_lock_cycle", lock_cyc1, 31);
        check("lane1_pulse_entries", pulse_t1.size(), 3);
        if (pulse_t1.size() == 3) begin
          check("lane1_first_pulse", pulse_t1[0], 1);
          check("lane1_pulse_gap_a", pulse_t1[1] - pulse_t1[0], 5);
          check("lane1_pulse_gap_b", pulse_t1[2] - pulse_t1[1], 5);
        end
      end
    end

    // Restart during WAIT after two slips
    setup(8'hE5, 0, 1'b0, 8'hE5, 5, 1'b0);
    start_align();
    cnt = 0; cyc = 0;
    while (cnt < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bitslip[1]) cnt++;
    end
    check("restart_two_slips_seen", cnt, 2);
    @(negedge clk);
    check("restart_pre_slip_count1", int'(slip_count[7:4]), 2);
    align_start = 1'b1;
    @(negedge clk);
    align_start = 1'b0;
    check("restart_slip_count1", int'(slip_count[7:4]), 0);
    check("restart_locked", int'(locked), 0);
    check("restart_align_err", int'(align_err), 0);
    run_until_done(400);
    check("restart_lane1_locked", int'(locked[1]), 1);
    check("restart_lane1_slips", int'(slip_count[7:4]), 1);
    check("restart_lane1_pulses", pulses1, 1);
    check("restart_align_done", int'(align_done), 1);

    // Asynchronous reset in the middle of a SLIP cycle
    setup(8'hE5, 0, 1'b0, 8'hE5, 5, 1'b0);
    start_align();
    cyc = 0;
    while (!bitslip[1] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_slip_reached", int'(bitslip[1]), 1);
    #1 reset = 1'b1;
    #1;
    check("rst_async_bitslip", int'(bitslip), 0);
    check("rst_async_locked", int'(locked), 0);
    check("rst_async_dout", int'(dout), 0);
    check("rst_async_slip_count", int'(slip_count), 0);
    check("rst_async_align_done", int'(align_done), 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (bitslip != 2'b00) cnt++; end
    check("rst_no_slip_after", cnt, 0);
    check("rst_still_unlocked", int'(locked), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
